my_pc_stack: RTL

Parametrised program counter with a hardware return-address stack, the successor to the fixed 16-bit load/inc/reset counter. Adds configurable width, subroutine call/return through a LIFO of depth DEPTH, stack-status outputs and sticky fault flags. Sits in the CPU between the control decoder (which asserts load/inc/call/ret) and instruction memory (which consumes `out` as the fetch address).

---
 rtl/my_pc_stack.sv | 88 ++++++++
 1 files changed

// File: rtl/my_pc_stack.sv
// Program counter with a LIFO return-address stack for subroutine call/return.
// One command per cycle with priority call > ret > load > inc > hold.
module my_pc_stack #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in,
  input  logic                         load,
  input  logic                         inc,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             out,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned SPW  = $clog2(DEPTH + 1);
  localparam int unsigned IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_INC,
    CMD_LOAD,
    CMD_RET,
    CMD_CALL
  } cmd_t;

  logic [WIDTH-1:0] stack [DEPTH];
  cmd_t             cmd;
  logic [IDXW-1:0]  push_idx;
  logic [IDXW-1:0]  pop_idx;
  logic [WIDTH-1:0] out_plus1;

  // Status flags decode straight from the registered stack pointer.
  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == SPW'(0));

  // Priority decode and address arithmetic (wraps modulo 2^WIDTH).
  always_comb begin
    cmd       = CMD_HOLD;
    push_idx  = IDXW'(sp);
    pop_idx   = IDXW'(sp - SPW'(1));
    out_plus1 = out + WIDTH'(1);
    if (call)      cmd = CMD_CALL;
    else if (ret)  cmd = CMD_RET;
    else if (load) cmd = CMD_LOAD;
    else if (inc)  cmd = CMD_INC;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      sp        <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) stack[i] <= '0;
    end else begin
      unique case (cmd)
        CMD_CALL: begin
          if (full) begin
            overflow <= 1'b1;
          end else begin
            stack[push_idx] <= out_plus1;
            sp              <= sp + SPW'(1);
            out             <= in;
          end
        end
        CMD_RET: begin
          if (empty) begin
            underflow <= 1'b1;
          end else begin
            out <= stack[pop_idx];
            sp  <= sp - SPW'(1);
          end
        end
        CMD_LOAD: out <= in;
        CMD_INC:  out <= out_plus1;
        default:  ;
      endcase
    end
  end

endmodule
